// File: rtl/in_service_ctrl_if.sv
// In-service controller bus: INTA handshake, EOI/priority commands and ISR status.
// The master is the resolver/command side; the slave is in_service_ctrl.
interface in_service_ctrl_if #(
  parameter int N_IRQ = 8
);
  localparam int IDX_W = (N_IRQ > 2) ? $clog2(N_IRQ) : 1;

  logic [IDX_W-1:0] irq_sel;
  logic             ack1;
  logic             ack2;
  logic             aeoi_mode;
  logic             rotate_en;
  logic             eoi_cmd;
  logic             eoi_specific;
  logic [IDX_W-1:0] eoi_level;
  logic             set_prio;
  logic [IDX_W-1:0] prio_level;

  logic [N_IRQ-1:0] isr;
  logic             isr_any;
  logic [IDX_W-1:0] highest_isr_idx;
  logic [IDX_W-1:0] lowest_prio;
  logic [IDX_W-1:0] last_serviced_idx;
  logic             last_serviced_vld;
  logic             proto_err;

  modport master (
    output irq_sel, ack1, ack2, aeoi_mode, rotate_en, eoi_cmd, eoi_specific,
           eoi_level, set_prio, prio_level,
    input  isr, isr_any, highest_isr_idx, lowest_prio, last_serviced_idx,
           last_serviced_vld, proto_err
  );

  modport slave (
    input  irq_sel, ack1, ack2, aeoi_mode, rotate_en, eoi_cmd, eoi_specific,
           eoi_level, set_prio, prio_level,
    output isr, isr_any, highest_isr_idx, lowest_prio, last_serviced_idx,
           last_serviced_vld, proto_err
  );
endinterface

// File: rtl/in_service_ctrl.sv
// PIC in-service register: INTA handshake FSM, auto/non-specific/specific EOI, rotating priority.
// Updates land one cycle after a strobe; no backpressure, every strobe is acted on or flagged.
module in_service_ctrl #(
  parameter int N_IRQ = 8
) (
  input logic              clk,
  input logic              rst_n,
  in_service_ctrl_if.slave bus
);
  localparam int IDX_W = (N_IRQ > 2) ? $clog2(N_IRQ) : 1;

  typedef logic [IDX_W-1:0] idx_t;
  typedef enum logic {IDLE, WAIT_ACK2} state_t;

  state_t           state;
  idx_t             cur_idx;
  idx_t             lowest_prio;
  idx_t             last_idx;
  logic             last_vld;
  logic             proto_err;
  logic [N_IRQ-1:0] isr;

  idx_t             hi_idx;
  logic             ack1_ok;
  logic             ack2_ok;
  logic             aeoi_clr;
  logic             eoi_clr;
  logic             sp_bad;
  logic             prio_ok;
  logic             err;
  logic             retire;
  idx_t             eoi_idx;
  idx_t             ret_idx;
  logic [N_IRQ-1:0] set_mask;
  logic [N_IRQ-1:0] clr_mask;
  logic [N_IRQ-1:0] isr_nxt;

  function automatic logic [N_IRQ-1:0] bit_of(input idx_t i);
    bit_of = '0;
    if (int'(i) < N_IRQ) bit_of[i] = 1'b1;
  endfunction

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    int t;
    hi_idx = '0;
    t = 0;
    for (int k = N_IRQ; k >= 1; k--) begin
      t = int'(lowest_prio) + k;
      if (t >= N_IRQ) t = t - N_IRQ;
      if (isr[t]) hi_idx = idx_t'(t);
    end
  end

  always_comb begin
    ack1_ok  = bus.ack1 && !bus.ack2 && (state == IDLE);
    ack2_ok  = bus.ack2 && !bus.ack1 && (state == WAIT_ACK2);
    aeoi_clr = ack2_ok && bus.aeoi_mode;
    sp_bad   = bus.eoi_cmd && bus.eoi_specific && (int'(bus.eoi_level) >= N_IRQ);
    eoi_clr  = bus.eoi_cmd && (bus.eoi_specific ? !sp_bad : (isr != '0));
    eoi_idx  = bus.eoi_specific ? bus.eoi_level : hi_idx;
    prio_ok  = bus.set_prio && (int'(bus.prio_level) < N_IRQ);
    err      = (bus.ack1 && bus.ack2)
            || (bus.ack1 && !bus.ack2 && (state == WAIT_ACK2))
            || (bus.ack2 && !bus.ack1 && (state == IDLE))
            || sp_bad
            || (bus.set_prio && !prio_ok);
    retire   = aeoi_clr || eoi_clr;
    // AEOI owns the retirement report and rotation when both fire together.
    ret_idx  = aeoi_clr ? cur_idx : eoi_idx;
    set_mask = ack1_ok ? bit_of(bus.irq_sel) : '0;
    clr_mask = (aeoi_clr ? bit_of(cur_idx) : '0) | (eoi_clr ? bit_of(eoi_idx) : '0);
    isr_nxt  = (isr & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cur_idx     <= '0;
      isr         <= '0;
      lowest_prio <= idx_t'(N_IRQ - 1);
      last_idx    <= '0;
      last_vld    <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      isr       <= isr_nxt;
      last_vld  <= retire;
      proto_err <= err;
      if (retire) last_idx <= ret_idx;
      if (prio_ok) lowest_prio <= bus.prio_level;
      else if (retire && bus.rotate_en) lowest_prio <= ret_idx;
      case (state)
        IDLE: begin
          if (ack1_ok) begin
            state   <= WAIT_ACK2;
            cur_idx <= bus.irq_sel;
          end
        end
        WAIT_ACK2: begin
          if (ack2_ok) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.isr               = isr;
  assign bus.isr_any           = |isr;
  assign bus.highest_isr_idx   = hi_idx;
  assign bus.lowest_prio       = lowest_prio;
  assign bus.last_serviced_idx = last_idx;
  assign bus.last_serviced_vld = last_vld;
  assign bus.proto_err         = proto_err;
endmodule

// File: tb/tb_in_service_ctrl.sv
// Directed bench for in_service_ctrl with N_IRQ=8 and N_IRQ=6 instances.
module tb_in_service_ctrl;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  in_service_ctrl_if #(.N_IRQ(8)) if8();
  in_service_ctrl_if #(.N_IRQ(6)) if6();

  in_service_ctrl #(.N_IRQ(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(if8));
  in_service_ctrl #(.N_IRQ(6)) u6 (.clk(clk), .rst_n(rst_n), .bus(if6));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    if8.irq_sel = '0; if8.ack1 = 0; if8.ack2 = 0; if8.eoi_cmd = 0; if8.eoi_specific = 0;
    if8.eoi_level = '0; if8.set_prio = 0; if8.prio_level = '0;
    if6.irq_sel = '0; if6.ack1 = 0; if6.ack2 = 0; if6.eoi_cmd = 0; if6.eoi_specific = 0;
    if6.eoi_level = '0; if6.set_prio = 0; if6.prio_level = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    if8.aeoi_mode = 0; if8.rotate_en = 0; if6.aeoi_mode = 0; if6.rotate_en = 0;
    rst_n = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  // Each strobe helper raises for one cycle; outputs are sampled at the following negedge.
  task automatic ack1_8(input logic [2:0] idx);
    if8.irq_sel = idx; if8.ack1 = 1; @(negedge clk); clear_inputs();
  endtask

  task automatic ack2_8();
    if8.ack2 = 1; @(negedge clk); clear_inputs();
  endtask

  task automatic eoi_8(input logic spec, input logic [2:0] lvl);
    if8.eoi_cmd = 1; if8.eoi_specific = spec; if8.eoi_level = lvl; @(negedge clk); clear_inputs();
  endtask

  task automatic prio_8(input logic [2:0] lvl);
    if8.set_prio = 1; if8.prio_level = lvl; @(negedge clk); clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    if8.aeoi_mode = 0; if8.rotate_en = 0; if6.aeoi_mode = 0; if6.rotate_en = 0;
    rst_n = 0;
    @(negedge clk);
    total++; if (if8.isr !== 8'h00) begin bad++; $display("FAIL reset_isr got=%h want=00", if8.isr); end
    total++; if (if8.isr_any !== 1'b0) begin bad++; $display("FAIL reset_isr_any got=%b want=0", if8.isr_any); end
    total++; if (if8.lowest_prio !== 3'd7) begin bad++; $display("FAIL reset_lowest8 got=%0d want=7", if8.lowest_prio); end
    total++; if (if6.lowest_prio !== 3'd5) begin bad++; $display("FAIL reset_lowest6 got=%0d want=5", if6.lowest_prio); end
    total++; if ({if8.highest_isr_idx, if8.last_serviced_idx, if8.last_serviced_vld, if8.proto_err} !== 8'h00) begin
      bad++; $display("FAIL reset_misc got=%h want=00", {if8.highest_isr_idx, if8.last_serviced_idx, if8.last_serviced_vld, if8.proto_err});
    end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    do_reset();
    ack1_8(3'd5);
    total++; if (if8.isr !== 8'h20) begin bad++; $display("FAIL basic_isr got=%h want=20", if8.isr); end
    total++; if (if8.highest_isr_idx !== 3'd5) begin bad++; $display("FAIL basic_hi got=%0d want=5", if8.highest_isr_idx); end
    ack2_8();
    total++; if (if8.isr !== 8'h20 || if8.proto_err !== 1'b0) begin bad++; $display("FAIL basic_ack2 got=%h/%b want=20/0", if8.isr, if8.proto_err); end
    eoi_8(1'b0, 3'd0);
    total++; if (if8.isr !== 8'h00) begin bad++; $display("FAIL basic_eoi_isr got=%h want=00", if8.isr); end
    total++; if (if8.last_serviced_idx !== 3'd5 || if8.last_serviced_vld !== 1'b1) begin
      bad++; $display("FAIL basic_eoi_last got=%0d/%b want=5/1", if8.last_serviced_idx, if8.last_serviced_vld);
    end
    @(negedge clk);
    total++; if (if8.last_serviced_vld !== 1'b0) begin bad++; $display("FAIL basic_vld_pulse got=%b want=0", if8.last_serviced_vld); end
    eoi_8(1'b0, 3'd0);
    total++; if (if8.last_serviced_vld !== 1'b0 || if8.proto_err !== 1'b0) begin
      bad++; $display("FAIL basic_empty_eoi got=%b/%b want=0/0", if8.last_serviced_vld, if8.proto_err);
    end
  endtask

  task automatic test_aeoi_rotate();
    do_reset();
    if8.aeoi_mode = 1; if8.rotate_en = 1;
    ack1_8(3'd3);
    total++; if (if8.isr !== 8'h08) begin bad++; $display("FAIL aeoi_set got=%h want=08", if8.isr); end
    ack2_8();
    total++; if (if8.isr !== 8'h00 || if8.lowest_prio !== 3'd3) begin
      bad++; $display("FAIL aeoi_clear got=%h/%0d want=00/3", if8.isr, if8.lowest_prio);
    end
    total++; if (if8.last_serviced_idx !== 3'd3 || if8.last_serviced_vld !== 1'b1) begin
      bad++; $display("FAIL aeoi_last got=%0d/%b want=3/1", if8.last_serviced_idx, if8.last_serviced_vld);
    end
    if8.aeoi_mode = 0; if8.rotate_en = 0;
    ack1_8(3'd0); ack2_8(); ack1_8(3'd4); ack2_8();
    total++; if (if8.isr !== 8'h11 || if8.highest_isr_idx !== 3'd4) begin
      bad++; $display("FAIL aeoi_rot_hi got=%h/%0d want=11/4", if8.isr, if8.highest_isr_idx);
    end
  endtask

  task automatic test_nested();
    do_reset();
    ack1_8(3'd6); ack2_8(); ack1_8(3'd2); ack2_8();
    total++; if (if8.isr !== 8'h44 || if8.highest_isr_idx !== 3'd2) begin
      bad++; $display("FAIL nest_isr got=%h/%0d want=44/2", if8.isr, if8.highest_isr_idx);
    end
    eoi_8(1'b0, 3'd0);
    total++; if (if8.isr !== 8'h40 || if8.last_serviced_idx !== 3'd2) begin
      bad++; $display("FAIL nest_eoi1 got=%h/%0d want=40/2", if8.isr, if8.last_serviced_idx);
    end
    eoi_8(1'b0, 3'd0);
    total++; if (if8.isr !== 8'h00 || if8.last_serviced_idx !== 3'd6) begin
      bad++; $display("FAIL nest_eoi2 got=%h/%0d want=00/6", if8.isr, if8.last_serviced_idx);
    end
    do_reset();
    prio_8(3'd1);
    total++; if (if8.lowest_prio !== 3'd1) begin bad++; $display("FAIL nest_setprio got=%0d want=1", if8.lowest_prio); end
    ack1_8(3'd6); ack2_8(); ack1_8(3'd2); ack2_8();
    eoi_8(1'b0, 3'd0);
    total++; if (if8.isr !== 8'h40) begin bad++; $display("FAIL nest_prio1_eoi got=%h want=40", if8.isr); end
    do_reset();
    prio_8(3'd3);
    ack1_8(3'd6); ack2_8(); ack1_8(3'd2); ack2_8();
    total++; if (if8.highest_isr_idx !== 3'd6) begin bad++; $display("FAIL nest_prio3_hi got=%0d want=6", if8.highest_isr_idx); end
    eoi_8(1'b0, 3'd0);
    total++; if (if8.isr !== 8'h04 || if8.last_serviced_idx !== 3'd6) begin
      bad++; $display("FAIL nest_prio3_eoi got=%h/%0d want=04/6", if8.isr, if8.last_serviced_idx);
    end
  endtask

  task automatic test_specific();
    do_reset();
    ack1_8(3'd6); ack2_8(); ack1_8(3'd2); ack2_8();
    eoi_8(1'b1, 3'd6);
    total++; if (if8.isr !== 8'h04 || if8.last_serviced_idx !== 3'd6 || if8.last_serviced_vld !== 1'b1) begin
      bad++; $display("FAIL spec_eoi got=%h/%0d/%b want=04/6/1", if8.isr, if8.last_serviced_idx, if8.last_serviced_vld);
    end
    eoi_8(1'b1, 3'd5);
    total++; if (if8.isr !== 8'h04 || if8.last_serviced_idx !== 3'd5 || if8.last_serviced_vld !== 1'b1) begin
      bad++; $display("FAIL spec_clear_bit got=%h/%0d/%b want=04/5/1", if8.isr, if8.last_serviced_idx, if8.last_serviced_vld);
    end
    if6.irq_sel = 3'd2; if6.ack1 = 1; @(negedge clk); clear_inputs();
    if6.ack2 = 1; @(negedge clk); clear_inputs();
    if6.eoi_cmd = 1; if6.eoi_specific = 1; if6.eoi_level = 3'd7; @(negedge clk); clear_inputs();
    total++; if (if6.isr !== 6'h04 || if6.proto_err !== 1'b1 || if6.last_serviced_vld !== 1'b0) begin
      bad++; $display("FAIL spec_range got=%h/%b/%b want=04/1/0", if6.isr, if6.proto_err, if6.last_serviced_vld);
    end
    if6.set_prio = 1; if6.prio_level = 3'd6; @(negedge clk); clear_inputs();
    total++; if (if6.lowest_prio !== 3'd5 || if6.proto_err !== 1'b1) begin
      bad++; $display("FAIL prio_range got=%0d/%b want=5/1", if6.lowest_prio, if6.proto_err);
    end
  endtask

  task automatic test_protocol();
    do_reset();
    ack2_8();
    total++; if (if8.proto_err !== 1'b1 || if8.isr !== 8'h00) begin
      bad++; $display("FAIL proto_ack2_idle got=%b/%h want=1/00", if8.proto_err, if8.isr);
    end
    @(negedge clk);
    total++; if (if8.proto_err !== 1'b0) begin bad++; $display("FAIL proto_err_pulse got=%b want=0", if8.proto_err); end
    ack1_8(3'd1);
    ack1_8(3'd3);
    total++; if (if8.proto_err !== 1'b1 || if8.isr !== 8'h02) begin
      bad++; $display("FAIL proto_double_ack1 got=%b/%h want=1/02", if8.proto_err, if8.isr);
    end
    ack2_8();
    total++; if (if8.proto_err !== 1'b0 || if8.isr !== 8'h02) begin
      bad++; $display("FAIL proto_ack2_ok got=%b/%h want=0/02", if8.proto_err, if8.isr);
    end
    if8.irq_sel = 3'd4; if8.ack1 = 1; if8.ack2 = 1; @(negedge clk); clear_inputs();
    total++; if (if8.proto_err !== 1'b1 || if8.isr !== 8'h02) begin
      bad++; $display("FAIL proto_both got=%b/%h want=1/02", if8.proto_err, if8.isr);
    end
    ack1_8(3'd4);
    total++; if (if8.isr !== 8'h12) begin bad++; $display("FAIL proto_pre_rst got=%h want=12", if8.isr); end
    rst_n = 0;
    #1;
    total++; if (if8.isr !== 8'h00 || if8.lowest_prio !== 3'd7 || if8.isr_any !== 1'b0) begin
      bad++; $display("FAIL proto_async_rst got=%h/%0d/%b want=00/7/0", if8.isr, if8.lowest_prio, if8.isr_any);
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    ack2_8();
    total++; if (if8.proto_err !== 1'b1) begin bad++; $display("FAIL proto_fsm_idle got=%b want=1", if8.proto_err); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    ack1_8(3'd1); ack2_8();
    if8.irq_sel = 3'd1; if8.ack1 = 1; if8.eoi_cmd = 1; if8.eoi_specific = 0;
    @(negedge clk); clear_inputs();
    total++; if (if8.isr !== 8'h02 || if8.last_serviced_idx !== 3'd1 || if8.last_serviced_vld !== 1'b1) begin
      bad++; $display("FAIL same_set_wins got=%h/%0d/%b want=02/1/1", if8.isr, if8.last_serviced_idx, if8.last_serviced_vld);
    end
    ack2_8();
    do_reset();
    ack1_8(3'd2); ack2_8();
    if8.aeoi_mode = 1; if8.rotate_en = 1;
    ack1_8(3'd5);
    if8.ack2 = 1; if8.eoi_cmd = 1; if8.eoi_specific = 1; if8.eoi_level = 3'd2;
    if8.set_prio = 1; if8.prio_level = 3'd0;
    @(negedge clk); clear_inputs();
    total++; if (if8.isr !== 8'h00 || if8.last_serviced_idx !== 3'd5 || if8.lowest_prio !== 3'd0) begin
      bad++; $display("FAIL same_aeoi_eoi got=%h/%0d/%0d want=00/5/0", if8.isr, if8.last_serviced_idx, if8.lowest_prio);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 0;
    test_reset();
    test_basic();
    test_aeoi_rotate();
    test_nested();
    test_specific();
    test_protocol();
    test_same_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/in_service_ctrl.md
# in_service_ctrl

Parametrised, synchronous in-service register (ISR) controller for the PIC interrupt path. It tracks which of `N_IRQ` interrupt levels are being serviced across the two-pulse INTA handshake. It retires levels by automatic, non-specific or specific EOI, and it maintains a rotating-priority pointer. It sits between the priority resolver, which supplies the winning request index, and the control/command logic, which supplies EOI and priority commands.

## Interface
- `N_IRQ`, default 8: number of interrupt levels; legal range 2..16. `IDX_W` = max(1, clog2(`N_IRQ`)) is derived, not overridable.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `irq_sel`  in  IDX_W  winning request index from the resolver; sampled on `ack1`.
- `ack1`  in  1  first INTA pulse, one-cycle strobe.
- `ack2`  in  1  second INTA pulse, one-cycle strobe.
- `aeoi_mode`  in  1  1 = automatic EOI on `ack2`.
- `rotate_en`  in  1  1 = rotate priority on each EOI (auto or commanded).
- `eoi_cmd`  in  1  one-cycle EOI command strobe.
- `eoi_specific`  in  1  qualifies `eoi_cmd`: 1 = specific, 0 = non-specific.
- `eoi_level`  in  IDX_W  target level for a specific EOI.
- `set_prio`  in  1  one-cycle strobe: load the lowest-priority pointer.
- `prio_level`  in  IDX_W  value loaded on `set_prio`.
- `isr`  out  N_IRQ  in-service vector, registered.
- `isr_any`  out  1  OR of `isr`.
- `highest_isr_idx`  out  IDX_W  highest-priority set bit of `isr` under current rotation; combinational; 0 when `isr_any`=0.
- `lowest_prio`  out  IDX_W  rotating pointer to the current lowest-priority level.
- `last_serviced_idx`  out  IDX_W  level most recently retired.
- `last_serviced_vld`  out  1  one-cycle pulse when a level is retired.
- `proto_err`  out  1  one-cycle pulse on a handshake or command violation.

## Operation
- Priority order: level (`lowest_prio`+1) mod `N_IRQ` is highest, descending cyclically to `lowest_prio`.
- Handshake FSM, two states:
  - IDLE: `ack1` sets `isr[irq_sel]`, latches `irq_sel` into `cur_idx`, and moves to WAIT_ACK2.
  - WAIT_ACK2, on `ack2`: return to IDLE. If `aeoi_mode`=1, clear `isr[cur_idx]`, set `last_serviced_idx`=`cur_idx`, pulse `last_serviced_vld`, and if `rotate_en`=1 set `lowest_prio`=`cur_idx`.
- Handshake violations: `ack2` in IDLE, or `ack1` in WAIT_ACK2, is ignored (no state or ISR change) and pulses `proto_err`. `ack1` and `ack2` high in the same cycle is also ignored and pulses `proto_err`.
- Non-specific EOI (`eoi_cmd`=1, `eoi_specific`=0):
  - Clears the bit at `highest_isr_idx`, updates `last_serviced_*`, and rotates `lowest_prio` to that index if `rotate_en`=1.
  - If `isr`=0: no effect and no error.
- Specific EOI (`eoi_specific`=1):
  - Clears `isr[eoi_level]` and updates `last_serviced_*` even if the bit was already clear; rotates `lowest_prio`=`eoi_level` if `rotate_en`=1.
  - If `eoi_level` ≥ `N_IRQ`: ignored, `proto_err` pulses.
- `set_prio`: `lowest_prio`=`prio_level`; out of range is ignored and pulses `proto_err`.
- `eoi_cmd` is accepted in either FSM state and in any `aeoi_mode`.
- Simultaneous events, same edge:
  - EOI selection is computed from the registered `isr` before the same-cycle `ack1` set.
  - A set and a clear on the same bit: the set wins.
  - An AEOI clear and a commanded EOI on different bits: both apply. `last_serviced_idx` and rotation take the AEOI index.
  - `set_prio` overrides any rotation in the same cycle.
- Reset (async, any time, including mid-handshake): `isr`=0, FSM=IDLE, `cur_idx`=0, `lowest_prio`=`N_IRQ`-1 (so level 0 is highest), `last_serviced_idx`=0, `last_serviced_vld`=0, `proto_err`=0.

## Timing
- All register updates take effect on the edge where the strobe is sampled high. Outputs reflect the update one cycle after the strobe is presented.
- `highest_isr_idx` and `isr_any` follow `isr` and `lowest_prio` combinationally, with no added latency.
- `ack1` to `ack2` spacing is unbounded; the FSM waits indefinitely in WAIT_ACK2.
- `last_serviced_vld` and `proto_err` are high for exactly one cycle per event.
- Strobes held high for multiple cycles are treated as repeated events.

## Test plan
- Reset, `N_IRQ`=8:
  - `ack1` with `irq_sel`=5, then `ack2`, `aeoi_mode`=0 → `isr`=0x20, `highest_isr_idx`=5.
  - Then a non-specific EOI → `isr`=0, `last_serviced_idx`=5, `last_serviced_vld` pulses once.
- AEOI with `rotate_en`=1: handshake on level 3 → after `ack2`, `isr`=0, `lowest_prio`=3, so level 4 becomes highest priority.
- Nested levels, default priority:
  - Service levels 6 then 2 → `isr`=0x44.
  - Non-specific EOI clears bit 2 first; a second EOI clears bit 6.
  - With `set_prio`=1 loaded beforehand, the first EOI clears bit 2, because level 2 is then highest.
- Specific EOI: `eoi_level`=6 with `isr`=0x44 → `isr`=0x04. With `N_IRQ`=6, `eoi_level`=7 → no change and `proto_err` pulses.
- Protocol: `ack2` in IDLE, and a double `ack1`, each → `proto_err` pulse with `isr` unchanged. Asserting `rst_n`=0 in WAIT_ACK2 → all outputs return to reset values and the FSM returns to IDLE.
- Same cycle: `ack1` on level 1 together with a non-specific EOI while `isr`=0x02 → `isr`=0x02 (set wins) and `last_serviced_idx`=1.
